mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Memory stage of the 5-stage 16-bit pipeline. It sits directly downstream of the Execute stage and consumes its 16-bit ALU result, store data and destination/control bits. It performs load, store, push and pop through a request/acknowledge data-memory port and owns the stack pointer. It stalls Execute with in_ready while a memory access is outstanding and delivers one result per instruction to Write-Back.

Parameters:
ADDR_W, 12, data-memory word-address width
SP_INIT, 12'hFFF, stack pointer value after reset (top of memory)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  Execute presents an instruction this cycle
in_ready  out  1  stage can accept; high only in IDLE
in_aluResult  in  16  ALU output; load/store address or pass-through data
in_storeData  in  16  register data for store/push
in_rd  in  3  destination register
in_regWrite  in  1  instruction writes a register
in_memRead  in  1  load
in_memWrite  in  1  store
in_push  in  1  push in_storeData
in_pop  in  1  pop into in_rd
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word address
mem_wdata  out  16  write data
mem_rdata  in  16  read data, valid with mem_ack
mem_ack  in  1  one-cycle completion pulse
out_valid  out  1  one-cycle pulse: result for Write-Back
out_data  out  16  loaded/popped word, or in_aluResult pass-through
out_rd  out  3  destination register
out_regWrite  out  1  write-enable for Write-Back
sp  out  ADDR_W  current stack pointer

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, sp=SP_INIT, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, out_valid=0, out_data=0, out_rd=0, out_regWrite=0. Reset mid-access abandons the access; a later mem_ack is ignored.
- States: IDLE, ACCESS.
- in_ready = (state==IDLE). An accept happens on a clk edge with in_valid & in_ready.
- Op decode, priority push > pop > memWrite > memRead > none. Multiple flags set: the highest-priority one is taken and the rest are ignored.
- No memory op: register out_data=in_aluResult, out_rd, out_regWrite, and pulse out_valid the next cycle. Latency 1, throughput 1/cycle, state stays IDLE.
- Memory op: on accept, latch rd/regWrite, drive mem_req=1 with addr/we/wdata, go to ACCESS.
  - store: addr=in_aluResult[ADDR_W-1:0], we=1, wdata=in_storeData.
  - load: same addr, we=0.
  - push: addr=sp, we=1, wdata=in_storeData.
  - pop: addr=sp+1 (mod 2^ADDR_W), we=0.
- ACCESS: mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack. On the mem_ack edge:
  - mem_req drops.
  - out_valid pulses the next cycle.
  - out_data = mem_rdata for load/pop; for store/push, out_data = in_aluResult latched at accept.
  - state returns to IDLE.
  - Minimum memory-op latency is 2 cycles, accept to out_valid, when mem_ack arrives in the first ACCESS cycle.
- sp update happens on the mem_ack edge only: push sp <= sp-1, pop sp <= sp+1. Both wrap modulo 2^ADDR_W (0-1 -> 2^ADDR_W-1).
- store/push force out_regWrite=0 regardless of input. load/pop use the input regWrite.
- mem_ack while in IDLE is ignored.
- out_valid is asserted for exactly one cycle per accepted instruction. There is no Write-Back backpressure.

Decomposition:
- Shared package: 16-bit data width, 3-bit register-index width, state encoding (IDLE=0, ACCESS=1), op encoding (NONE, LOAD, STORE, PUSH, POP).
- One sub-module is natural: stack_pointer_unit (sp register, inc/dec with wrap, addr = sp or sp+1 selection).
- FSM and pipeline output register stay in mem_access_stage.

Test Plan:
- Pass-through: accept aluResult=16'h1234, rd=5, regWrite=1, no mem flags -> next cycle out_valid=1, out_data=16'h1234, out_rd=5; mem_req stays 0; in_ready stays 1 for back-to-back.
- Load with 3-cycle wait: aluResult=16'h0040, memRead=1, ack after 3 cycles with rdata=16'hBEEF -> mem_req held with addr=12'h040, we=0; in_ready=0 throughout; out_data=16'hBEEF one cycle after ack.
- Push then pop: after reset push storeData=16'hAAAA -> mem_addr=12'hFFF, we=1, sp=12'hFFE after ack; pop rd=2 -> mem_addr=12'hFFF, sp=12'hFFF, out_data=rdata, out_regWrite=1.
- Wrap: set sp to 12'h000 via pushes, push -> sp=12'hFFF; pop at sp=12'hFFF reads addr 12'h000 -> sp=12'h000.
- Reset mid-access: assert rst_n=0 while in ACCESS, then send mem_ack after release -> mem_req=0, sp=SP_INIT, out_valid stays 0, in_ready=1.
- Conflicting flags: memRead=memWrite=push=1 -> push performed (we=1, addr=sp); spurious mem_ack in IDLE produces no out_valid.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the pipeline memory stage.
// Covers data/register widths, FSM state codes and memory-op decode.
package mem_access_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4
    } op_e;

    // Priority push > pop > store > load; lower-priority flags are dropped.
    function automatic op_e decode_op(
        input logic push,
        input logic pop,
        input logic mem_write,
        input logic mem_read
    );
        op_e op;
        if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end else if (mem_write) begin
            op = OP_STORE;
        end else if (mem_read) begin
            op = OP_LOAD;
        end else begin
            op = OP_NONE;
        end
        return op;
    endfunction

endpackage

// File: rtl/mem_access_stage_sp.sv
// Stack pointer register with wrapping inc/dec and the push/pop address select.
// The pointer addresses the next free slot, so pop reads from sp+1.
module stack_pointer_unit #(
    parameter int               ADDR_W  = 12,
    parameter logic [ADDR_W-1:0] SP_INIT = 12'hFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push_done,
    input  logic              i_pop_done,
    input  logic              i_sel_next,
    output logic [ADDR_W-1:0] o_sp,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] r_sp;
    logic [ADDR_W-1:0] w_sp_inc;
    logic [ADDR_W-1:0] w_sp_dec;

    assign w_sp_inc = r_sp + ADDR_W'(1);
    assign w_sp_dec = r_sp - ADDR_W'(1);

    // Pointer moves only when the memory side confirms the push or pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sp <= SP_INIT;
        end else if (i_push_done) begin
            r_sp <= w_sp_dec;
        end else if (i_pop_done) begin
            r_sp <= w_sp_inc;
        end else begin
            r_sp <= r_sp;
        end
    end

    assign o_sp   = r_sp;
    assign o_addr = i_sel_next ? w_sp_inc : r_sp;

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: load/store/push/pop over a req/ack data port, stalling Execute
// while an access is outstanding and emitting one registered result per instruction.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int                ADDR_W  = 12,
    parameter logic [ADDR_W-1:0] SP_INIT = 12'hFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_aluResult,
    input  logic [DATA_W-1:0] in_storeData,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_regWrite,
    input  logic              in_memRead,
    input  logic              in_memWrite,
    input  logic              in_push,
    input  logic              in_pop,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_regWrite,
    output logic [ADDR_W-1:0] sp
);

    logic [0:0]        r_state;
    op_e               r_op;
    logic [REG_W-1:0]  r_rd;
    logic              r_regwrite;
    logic [DATA_W-1:0] r_alu;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [REG_W-1:0]  r_out_rd;
    logic              r_out_regwrite;

    op_e               w_op;
    logic              w_accept;
    logic              w_ack_done;
    logic [ADDR_W-1:0] w_sp;
    logic [ADDR_W-1:0] w_sp_addr;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_req_we;
    logic [DATA_W-1:0] w_req_wdata;
    logic              w_keep_regwrite;

    assign in_ready   = (r_state == ST_IDLE);
    assign w_accept   = in_valid && in_ready;
    assign w_ack_done = (r_state == ST_ACCESS) && mem_ack;

    stack_pointer_unit #(
        .ADDR_W  (ADDR_W),
        .SP_INIT (SP_INIT)
    ) u_sp (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push_done (w_ack_done && (r_op == OP_PUSH)),
        .i_pop_done  (w_ack_done && (r_op == OP_POP)),
        .i_sel_next  (w_op == OP_POP),
        .o_sp        (w_sp),
        .o_addr      (w_sp_addr)
    );

    // Decode the incoming op and form the request it would launch.
    always_comb begin
        w_op            = decode_op(in_push, in_pop, in_memWrite, in_memRead);
        w_req_addr      = in_aluResult[ADDR_W-1:0];
        w_req_we        = 1'b0;
        w_req_wdata     = in_storeData;
        w_keep_regwrite = in_regWrite;
        case (w_op)
            OP_PUSH: begin
                w_req_addr      = w_sp_addr;
                w_req_we        = 1'b1;
                w_keep_regwrite = 1'b0;
            end
            OP_POP: begin
                w_req_addr = w_sp_addr;
            end
            OP_STORE: begin
                w_req_we        = 1'b1;
                w_keep_regwrite = 1'b0;
            end
            OP_LOAD: begin
                w_req_we = 1'b0;
            end
            default: begin
                w_req_we = 1'b0;
            end
        endcase
    end

    // FSM, held memory request and Write-Back output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_op           <= OP_NONE;
            r_rd           <= '0;
            r_regwrite     <= 1'b0;
            r_alu          <= '0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_rd       <= '0;
            r_out_regwrite <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (w_op == OP_NONE)) begin
                        r_out_valid    <= 1'b1;
                        r_out_data     <= in_aluResult;
                        r_out_rd       <= in_rd;
                        r_out_regwrite <= in_regWrite;
                    end else if (w_accept) begin
                        r_state     <= ST_ACCESS;
                        r_op        <= w_op;
                        r_rd        <= in_rd;
                        r_regwrite  <= w_keep_regwrite;
                        r_alu       <= in_aluResult;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_req_we;
                        r_mem_addr  <= w_req_addr;
                        r_mem_wdata <= w_req_wdata;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ack) begin
                        r_state        <= ST_IDLE;
                        r_mem_req      <= 1'b0;
                        r_out_valid    <= 1'b1;
                        r_out_rd       <= r_rd;
                        r_out_regwrite <= r_regwrite;
                        if ((r_op == OP_LOAD) || (r_op == OP_POP)) begin
                            r_out_data <= mem_rdata;
                        end else begin
                            r_out_data <= r_alu;
                        end
                    end else begin
                        r_state <= ST_ACCESS;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_rd       = r_out_rd;
    assign out_regWrite = r_out_regwrite;
    assign sp           = w_sp;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed-vector bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_aluResult;
    logic [15:0] in_storeData;
    logic [2:0]  in_rd;
    logic        in_regWrite;
    logic        in_memRead;
    logic        in_memWrite;
    logic        in_push;
    logic        in_pop;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        out_valid;
    logic [15:0] out_data;
    logic [2:0]  out_rd;
    logic        out_regWrite;
    logic [11:0] sp;

    int n_vec = 0;
    int n_err = 0;

    mem_access_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_aluResult (in_aluResult),
        .in_storeData (in_storeData),
        .in_rd        (in_rd),
        .in_regWrite  (in_regWrite),
        .in_memRead   (in_memRead),
        .in_memWrite  (in_memWrite),
        .in_push      (in_push),
        .in_pop       (in_pop),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_rd       (out_rd),
        .out_regWrite (out_regWrite),
        .sp           (sp)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] alu, input logic [15:0] sdata, input logic [2:0] rd,
                         input logic rw, input logic rdf, input logic wrf, input logic psh, input logic pp);
        in_valid     = 1'b1;
        in_aluResult = alu;
        in_storeData = sdata;
        in_rd        = rd;
        in_regWrite  = rw;
        in_memRead   = rdf;
        in_memWrite  = wrf;
        in_push      = psh;
        in_pop       = pp;
        step();
        in_valid    = 1'b0;
        in_memRead  = 1'b0;
        in_memWrite = 1'b0;
        in_push     = 1'b0;
        in_pop      = 1'b0;
    endtask

    task automatic do_ack(input int wait_cycles, input logic [15:0] rdata);
        repeat (wait_cycles) step();
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ack   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_aluResult = 16'h0000; in_storeData = 16'h0000; in_rd = 3'd0;
        in_regWrite = 1'b0; in_memRead = 1'b0; in_memWrite = 1'b0; in_push = 1'b0; in_pop = 1'b0;
        mem_rdata = 16'h0000; mem_ack = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        check_val("rst_ready", 32'(in_ready), 32'd1);
        check_val("rst_req", 32'(mem_req), 32'd0);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_sp", 32'(sp), 32'h0FFF);
        check_val("rst_addr", 32'(mem_addr), 32'h0000);
        check_val("rst_data", 32'(out_data), 32'h0000);

        // Pass-through, back to back
        issue(16'h1234, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("pt_valid", 32'(out_valid), 32'd1);
        check_val("pt_data", 32'(out_data), 32'h1234);
        check_val("pt_rd", 32'(out_rd), 32'd5);
        check_val("pt_rw", 32'(out_regWrite), 32'd1);
        check_val("pt_req", 32'(mem_req), 32'd0);
        check_val("pt_ready", 32'(in_ready), 32'd1);
        issue(16'h5678, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("pt2_valid", 32'(out_valid), 32'd1);
        check_val("pt2_data", 32'(out_data), 32'h5678);
        check_val("pt2_rw", 32'(out_regWrite), 32'd0);
        step();
        check_val("pt_idle_valid", 32'(out_valid), 32'd0);

        // Load with a 3-cycle wait
        issue(16'h0040, 16'h0000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_val("ld_req", 32'(mem_req), 32'd1);
            check_val("ld_addr", 32'(mem_addr), 32'h0040);
            check_val("ld_we", 32'(mem_we), 32'd0);
            check_val("ld_ready", 32'(in_ready), 32'd0);
            check_val("ld_valid_wait", 32'(out_valid), 32'd0);
            if (i < 2) step();
        end
        do_ack(1, 16'hBEEF);
        check_val("ld_valid", 32'(out_valid), 32'd1);
        check_val("ld_data", 32'(out_data), 32'hBEEF);
        check_val("ld_rd", 32'(out_rd), 32'd4);
        check_val("ld_rw", 32'(out_regWrite), 32'd1);
        check_val("ld_req_drop", 32'(mem_req), 32'd0);
        check_val("ld_ready_back", 32'(in_ready), 32'd1);
        step();
        check_val("ld_pulse_end", 32'(out_valid), 32'd0);

        // Push then pop
        issue(16'h0011, 16'hAAAA, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("push_addr", 32'(mem_addr), 32'h0FFF);
        check_val("push_we", 32'(mem_we), 32'd1);
        check_val("push_wdata", 32'(mem_wdata), 32'hAAAA);
        check_val("push_sp_hold", 32'(sp), 32'h0FFF);
        do_ack(0, 16'h0000);
        check_val("push_sp", 32'(sp), 32'h0FFE);
        check_val("push_valid", 32'(out_valid), 32'd1);
        check_val("push_rw", 32'(out_regWrite), 32'd0);
        check_val("push_data", 32'(out_data), 32'h0011);
        issue(16'h0000, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("pop_addr", 32'(mem_addr), 32'h0FFF);
        check_val("pop_we", 32'(mem_we), 32'd0);
        do_ack(0, 16'h5A5A);
        check_val("pop_sp", 32'(sp), 32'h0FFF);
        check_val("pop_data", 32'(out_data), 32'h5A5A);
        check_val("pop_rw", 32'(out_regWrite), 32'd1);
        check_val("pop_rd", 32'(out_rd), 32'd2);

        // Walk sp down to zero, then wrap both directions
        for (int i = 0; i < 4095; i++) begin
            issue(16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            do_ack(0, 16'h0000);
        end
        check_val("walk_sp", 32'(sp), 32'h0000);
        issue(16'h0000, 16'h0001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("wrap_push_addr", 32'(mem_addr), 32'h0000);
        do_ack(0, 16'h0000);
        check_val("wrap_push_sp", 32'(sp), 32'h0FFF);
        issue(16'h0000, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("wrap_pop_addr", 32'(mem_addr), 32'h0000);
        do_ack(0, 16'hC0DE);
        check_val("wrap_pop_sp", 32'(sp), 32'h0000);
        check_val("wrap_pop_data", 32'(out_data), 32'hC0DE);

        // Reset in the middle of a load; the late ack must be ignored
        issue(16'h0123, 16'h0000, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("mr_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        do_ack(0, 16'h1111);
        check_val("mr_req_low", 32'(mem_req), 32'd0);
        check_val("mr_sp", 32'(sp), 32'h0FFF);
        check_val("mr_valid", 32'(out_valid), 32'd0);
        check_val("mr_ready", 32'(in_ready), 32'd1);

        // Conflicting flags: push wins
        issue(16'h0300, 16'h7777, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("cf_we", 32'(mem_we), 32'd1);
        check_val("cf_addr", 32'(mem_addr), 32'h0FFF);
        check_val("cf_wdata", 32'(mem_wdata), 32'h7777);
        do_ack(0, 16'h0000);
        check_val("cf_sp", 32'(sp), 32'h0FFE);
        check_val("cf_rw", 32'(out_regWrite), 32'd0);
        check_val("cf_data", 32'(out_data), 32'h0300);
        step();
        do_ack(0, 16'h2222);
        check_val("spur_valid", 32'(out_valid), 32'd0);
        check_val("spur_sp", 32'(sp), 32'h0FFE);
        check_val("spur_ready", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
